// File: rtl/shake_input_loader.sv
// shake_input_loader: packs a 64-bit little-endian message word stream into
// one rate-sized block and applies SHAKE padding: a 0x1F domain byte after
// the message, zero fill, and 0x80 ORed into the final byte of the block.
// Handshake: a message word moves when in_valid & in_ready are both high at a
// rising clock edge. in_ready is high only in FILL. A full block is offered
// through input_buffer_ready, and the permute FSM consumes it with a pulse on
// input_buffer_ready_clr or absorb_enable.
module shake_input_loader #(
    parameter int RATE_WORDS = 21
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [63:0]             in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [3:0]              in_bytes,
    output logic                    in_ready,
    input  logic                    input_buffer_ready_clr,
    input  logic                    absorb_enable,
    input  logic                    last_block_in_buffer_clr,
    output logic                    input_buffer_ready,
    output logic                    last_block_in_input_buffer,
    output logic [64*RATE_WORDS-1:0] block_data,
    output logic [1:0]              dbg_state
);

    localparam int CW = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(RATE_WORDS - 1);
    localparam logic [63:0] TOP_PAD = 64'h8000_0000_0000_0000;
    localparam logic [63:0] DOMAIN = 64'h0000_0000_0000_001F;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           word_cnt_q, word_cnt_d;
    logic                    pad_pending_q, pad_pending_d;
    logic                    first_pad_q, first_pad_d;
    logic                    in_ready_q, in_ready_d;
    logic                    ibr_q, ibr_d;
    logic                    last_blk_q, last_blk_d;
    logic [64*RATE_WORDS-1:0] block_q, block_d;

    logic        consume;
    logic        last_slot;
    logic [3:0]  eff_bytes;
    logic [5:0]  byte_shift;
    logic [63:0] keep_mask;
    logic [63:0] tail_word;
    logic [63:0] pad_word;
    logic        wr_en;
    logic [63:0] wr_word;
    logic        enter_last;

    // Next-state, block write and handshake flag computation.
    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        pad_pending_d = pad_pending_q;
        first_pad_d   = first_pad_q;
        ibr_d         = ibr_q;
        last_blk_d    = last_blk_q;
        block_d       = block_q;
        wr_en         = 1'b0;
        wr_word       = 64'd0;
        enter_last    = 1'b0;

        consume    = input_buffer_ready_clr | absorb_enable;
        last_slot  = (word_cnt_q == LAST_IDX);
        // Byte counts above 8 saturate to a full word.
        eff_bytes  = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
        byte_shift = {eff_bytes[2:0], 3'b000};
        keep_mask  = (64'd1 << byte_shift) - 64'd1;
        tail_word  = (in_data & keep_mask) | (DOMAIN << byte_shift);
        pad_word   = (first_pad_q ? DOMAIN : 64'd0) | (last_slot ? TOP_PAD : 64'd0);

        case (state_q)
            ST_FILL: begin
                if (in_valid && in_ready_q) begin
                    wr_en   = 1'b1;
                    wr_word = in_data;
                    if (in_last && (eff_bytes != 4'd8)) begin
                        // Partial last word carries the domain byte itself.
                        wr_word = tail_word | (last_slot ? TOP_PAD : 64'd0);
                        if (last_slot) begin
                            state_d    = ST_FULL;
                            enter_last = 1'b1;
                        end else begin
                            state_d     = ST_PAD;
                            first_pad_d = 1'b0;
                        end
                    end else if (in_last) begin
                        // Full last word: domain byte goes into the next word,
                        // which may live in an extra block.
                        if (last_slot) begin
                            state_d       = ST_FULL;
                            pad_pending_d = 1'b1;
                        end else begin
                            state_d     = ST_PAD;
                            first_pad_d = 1'b1;
                        end
                    end else if (last_slot) begin
                        state_d = ST_FULL;
                    end
                    word_cnt_d = last_slot ? '0 : word_cnt_q + 1'b1;
                end
            end
            ST_PAD: begin
                wr_en       = 1'b1;
                wr_word     = pad_word;
                first_pad_d = 1'b0;
                if (last_slot) begin
                    state_d    = ST_FULL;
                    enter_last = 1'b1;
                    word_cnt_d = '0;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            ST_FULL: begin
                if (consume) begin
                    ibr_d      = 1'b0;
                    word_cnt_d = '0;
                    if (pad_pending_q) begin
                        pad_pending_d = 1'b0;
                        first_pad_d   = 1'b1;
                        state_d       = ST_PAD;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase

        for (int i = 0; i < RATE_WORDS; i++) begin
            if (wr_en && (word_cnt_q == CW'(i))) begin
                block_d[64*i +: 64] = wr_word;
            end
        end

        if ((state_q != ST_FULL) && (state_d == ST_FULL)) begin
            ibr_d      = 1'b1;
            last_blk_d = enter_last;
        end
        // The permute FSM's clear beats a same-cycle set.
        if (last_block_in_buffer_clr) begin
            last_blk_d = 1'b0;
        end

        in_ready_d = (state_d == ST_FILL);
    end

    // State and output registers; reset discards any message in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_FILL;
            word_cnt_q    <= '0;
            pad_pending_q <= 1'b0;
            first_pad_q   <= 1'b0;
            in_ready_q    <= 1'b0;
            ibr_q         <= 1'b0;
            last_blk_q    <= 1'b0;
            block_q       <= '0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            pad_pending_q <= pad_pending_d;
            first_pad_q   <= first_pad_d;
            in_ready_q    <= in_ready_d;
            ibr_q         <= ibr_d;
            last_blk_q    <= last_blk_d;
            block_q       <= block_d;
        end
    end

    assign in_ready                   = in_ready_q;
    assign input_buffer_ready         = ibr_q;
    assign last_block_in_input_buffer = last_blk_q;
    assign block_data                 = block_q;
    assign dbg_state                  = state_q;

endmodule

// File: tb/tb_shake_input_loader.sv
// Bench for shake_input_loader: random messages are padded by a byte-level
// reference (append 0x1F, zero fill to the rate, OR 0x80 into the last byte)
// and every offered block is compared word by word.
module tb_shake_input_loader;

    localparam int RW = 21;
    localparam int BB = RW * 8;

    logic                clk;
    logic                rst;
    logic [63:0]         in_data;
    logic                in_valid;
    logic                in_last;
    logic [3:0]          in_bytes;
    logic                in_ready;
    logic                input_buffer_ready_clr;
    logic                absorb_enable;
    logic                last_block_in_buffer_clr;
    logic                input_buffer_ready;
    logic                last_block_in_input_buffer;
    logic [64*RW-1:0]    block_data;
    logic [1:0]          dbg_state;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [7:0]  pb[$];
    logic [63:0] exp_q[$];
    logic [63:0] msg_w[$];

    shake_input_loader #(.RATE_WORDS(RW)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .in_data                    (in_data),
        .in_valid                   (in_valid),
        .in_last                    (in_last),
        .in_bytes                   (in_bytes),
        .in_ready                   (in_ready),
        .input_buffer_ready_clr     (input_buffer_ready_clr),
        .absorb_enable              (absorb_enable),
        .last_block_in_buffer_clr   (last_block_in_buffer_clr),
        .input_buffer_ready         (input_buffer_ready),
        .last_block_in_input_buffer (last_block_in_input_buffer),
        .block_data                 (block_data),
        .dbg_state                  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid                 = 1'b0;
        input_buffer_ready_clr   = 1'b0;
        absorb_enable            = 1'b0;
        last_block_in_buffer_clr = 1'b0;
    endtask

    // Send one message of nwords words (last word holds lastb bytes), check
    // every block it produces, and consume each block after hold idle cycles.
    task automatic run_msg(input int nwords, input int lastb, input int hold, input bit clr_first);
        logic [63:0] w;
        int nb;
        int wi;
        int drive_cyc;
        int exp_lat;
        int budget;
        bit lat_done;
        bit just_consumed;
        bit is_final;

        msg_w.delete();
        pb.delete();
        exp_q.delete();
        for (int i = 0; i < nwords; i++) begin
            w = {$urandom, $urandom};
            msg_w.push_back(w);
            nb = (i == nwords - 1) ? ((lastb > 8) ? 8 : lastb) : 8;
            for (int k = 0; k < nb; k++) pb.push_back(w[8*k +: 8]);
        end
        pb.push_back(8'h1F);
        while ((pb.size() % BB) != 0) pb.push_back(8'h00);
        pb[pb.size()-1] = pb[pb.size()-1] | 8'h80;
        for (int i = 0; i < pb.size() / 8; i++) begin
            w = '0;
            for (int k = 0; k < 8; k++) w[8*k +: 8] = pb[8*i + k];
            exp_q.push_back(w);
        end

        // Words still to be filled after the last message word, plus one.
        exp_lat       = RW - ((nwords - 1) % RW);
        wi            = 0;
        drive_cyc     = -1;
        lat_done      = 1'b0;
        just_consumed = 1'b0;
        budget        = 0;

        while (exp_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            budget++;
            if (budget > 3000) begin
                check("timeout_block", 64'(exp_q.size()), 64'd0);
                idle_inputs();
                return;
            end
            idle_inputs();
            if (just_consumed) begin
                check("ibr_after_consume", 64'(input_buffer_ready), 64'd0);
                just_consumed = 1'b0;
            end
            if (input_buffer_ready) begin
                if (drive_cyc >= 0 && !lat_done) begin
                    check("latency", 64'(cyc - drive_cyc), 64'(exp_lat));
                    lat_done = 1'b1;
                end
                is_final = (exp_q.size() == RW);
                for (int i = 0; i < RW; i++) check($sformatf("word%0d", i), block_data[64*i +: 64], exp_q[i]);
                check("last_flag", 64'(last_block_in_input_buffer), 64'(is_final));
                check("in_ready_full", 64'(in_ready), 64'd0);
                check("state_full", 64'(dbg_state), 64'd2);
                for (int h = 0; h < hold; h++) begin
                    if (wi < nwords) begin
                        in_data  = msg_w[wi];
                        in_last  = (wi == nwords - 1);
                        in_bytes = (wi == nwords - 1) ? 4'(lastb) : 4'($urandom_range(0, 15));
                        in_valid = 1'b1;
                    end
                    @(negedge clk);
                    cyc++;
                    check("hold_in_ready", 64'(in_ready), 64'd0);
                    check("hold_ibr", 64'(input_buffer_ready), 64'd1);
                    check("hold_word0", block_data[63:0], exp_q[0]);
                    check("hold_wordlast", block_data[64*(RW-1) +: 64], exp_q[RW-1]);
                end
                if (clr_first && is_final) begin
                    last_block_in_buffer_clr = 1'b1;
                    @(negedge clk);
                    cyc++;
                    last_block_in_buffer_clr = 1'b0;
                    check("clr_last", 64'(last_block_in_input_buffer), 64'd0);
                    check("clr_keeps_ibr", 64'(input_buffer_ready), 64'd1);
                end
                if ($urandom_range(0, 1) == 1) input_buffer_ready_clr = 1'b1;
                else absorb_enable = 1'b1;
                if (is_final) last_block_in_buffer_clr = 1'b1;
                for (int i = 0; i < RW; i++) void'(exp_q.pop_front());
                just_consumed = 1'b1;
            end else if (in_ready && wi < nwords) begin
                in_data  = msg_w[wi];
                in_last  = (wi == nwords - 1);
                in_bytes = (wi == nwords - 1) ? 4'(lastb) : 4'($urandom_range(0, 15));
                in_valid = 1'b1;
                if (wi == nwords - 1) drive_cyc = cyc;
                wi++;
            end
        end
        @(negedge clk);
        cyc++;
        idle_inputs();
        check("end_ibr", 64'(input_buffer_ready), 64'd0);
        check("end_last", 64'(last_block_in_input_buffer), 64'd0);
        check("end_in_ready", 64'(in_ready), 64'd1);
    endtask

    // Directed sequence
    initial begin
        rst      = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_bytes = '0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_ibr", 64'(input_buffer_ready), 64'd0);
        check("rst_last", 64'(last_block_in_input_buffer), 64'd0);
        check("rst_block", 64'(|block_data), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_state", 64'(dbg_state), 64'd0);

        run_msg(1, 0, 0, 1'b0);     // empty message
        run_msg(22, 3, 0, 1'b0);    // spills into a second block
        run_msg(21, 8, 0, 1'b0);    // pad-only extra block
        run_msg(21, 7, 0, 1'b1);    // 0x9F final byte, standalone last clear
        run_msg(30, 5, 10, 1'b0);   // backpressure
        run_msg(20, 12, 0, 1'b0);   // oversized byte count saturates
        for (int t = 0; t < 6; t++) begin
            run_msg($urandom_range(1, 50), $urandom_range(0, 8), $urandom_range(0, 3), 1'(t % 2));
        end

        // Reset in the middle of padding.
        @(negedge clk);
        in_data  = {$urandom, $urandom};
        in_last  = 1'b1;
        in_bytes = 4'd2;
        in_valid = 1'b1;
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        check("mid_pad_state", 64'(dbg_state), 64'd1);
        rst = 1'b0;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd0);
        check("arst_ibr", 64'(input_buffer_ready), 64'd0);
        check("arst_last", 64'(last_block_in_input_buffer), 64'd0);
        check("arst_block", 64'(|block_data), 64'd0);
        check("arst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("arst_release_in_ready", 64'(in_ready), 64'd1);
        run_msg(3, 4, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
